// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

   typedef enum logic [1:0] {
      HEADER = 2'd0,
      LOAD   = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } loader_state_t;

   localparam int          LOADER_HDR_BYTES = 4;
   localparam logic [31:0] INST_NOP         = 32'h0800_0000;

   // Number of words the target memory can hold, as a 32-bit count.
   function automatic logic [31:0] loader_capacity(input int addr_width);
      loader_capacity = 32'd1 << addr_width;
   endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream and flags word completion.
module byte_word_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        accept,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_BYTE = 2'(LOADER_HDR_BYTES - 1);

   // Only the first three bytes need storing; the fourth is taken straight
   // from rx_data so the completed word is usable on the sampling edge.
   logic [23:0] hold_q, hold_d;
   logic [1:0]  cnt_q, cnt_d;

   // Shift in accepted bytes and advance the wrapping byte counter.
   always_comb begin
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      word_valid = 1'b0;
      word       = {hold_q, rx_data};
      if (rx_valid && accept) begin
         hold_d     = {hold_q[15:0], rx_data};
         cnt_d      = cnt_q + 2'd1;
         word_valid = (cnt_q == LAST_BYTE);
      end else begin
         hold_d     = hold_q;
         cnt_d      = cnt_q;
         word_valid = 1'b0;
      end
   end

   // Packer state registers; reset drops any partial word.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= 24'd0;
         cnt_q  <= 2'd0;
      end else begin
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/inst_loader_checker.sv
// Protocol checker: a write strobe needs the load window open for two prior cycles.
module inst_loader_checker (
   input logic CLK,
   input logic reset,
   input logic loader_enable,
   input logic loader_ready
);

   logic en_h1_q, en_h1_d;
   logic en_h2_q, en_h2_d;

   // Shift the load-window level into a two-cycle history.
   always_comb begin
      en_h1_d = loader_enable;
      en_h2_d = en_h1_q;
   end

   // History registers.
   always_ff @(posedge CLK) begin
      if (reset) begin
         en_h1_q <= 1'b0;
         en_h2_q <= 1'b0;
      end else begin
         en_h1_q <= en_h1_d;
         en_h2_q <= en_h2_d;
      end
   end

   // A strobe is only legal inside a window that has been open for two cycles.
   always @(posedge CLK) begin
      if (!reset) begin
         assert (!loader_ready || (loader_enable && en_h1_q && en_h2_q))
            else $error("sink guard violated: ready without settled enable");
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Load sequencer: reads a word count header, then streams words to instruction memory.
module inst_loader
   import loader_pkg::*;
#(
   parameter int INST_MEM_WIDTH = 2
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic [31:0]             loader_data,
   output logic                    loader_enable,
   output logic                    loader_ready,
   output logic                    done,
   output logic [INST_MEM_WIDTH:0] words_loaded
);

   localparam logic [31:0]             CAPACITY    = loader_capacity(INST_MEM_WIDTH);
   localparam logic [INST_MEM_WIDTH:0] CAPACITY_WL = {1'b1, {INST_MEM_WIDTH{1'b0}}};
   localparam logic [INST_MEM_WIDTH:0] ONE_WL      = {{INST_MEM_WIDTH{1'b0}}, 1'b1};

   loader_state_t             state_q, state_d;
   logic [31:0]               n_q, n_d;
   logic [31:0]               idx_q, idx_d;
   logic [31:0]               data_q, data_d;
   logic                      en_q, en_d;
   logic                      rdy_q, rdy_d;
   logic                      done_q, done_d;
   logic [INST_MEM_WIDTH:0]   wl_q, wl_d;

   logic                      accept;
   logic [31:0]               word;
   logic                      word_valid;

   // Bytes are consumed only while a header or data word can still arrive.
   always_comb begin
      accept = (state_q == HEADER) || (state_q == LOAD);
   end

   byte_word_packer u_packer (
      .clk        (CLK),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .accept     (accept),
      .word       (word),
      .word_valid (word_valid)
   );

   // Sequencer next-state and output computation.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      data_d  = data_q;
      en_d    = en_q;
      rdy_d   = 1'b0;
      done_d  = done_q;
      wl_d    = wl_q;
      case (state_q)
         HEADER: begin
            if (word_valid) begin
               n_d   = word;
               idx_d = 32'd0;
               if (word == 32'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOAD;
                  en_d    = 1'b1;
               end
            end else begin
               state_d = HEADER;
            end
         end
         LOAD: begin
            if (word_valid) begin
               // idx_q < n_q here, so the increment cannot wrap.
               idx_d = idx_q + 32'd1;
               if (idx_q < CAPACITY) begin
                  data_d = word;
                  rdy_d  = 1'b1;
                  if (wl_q < CAPACITY_WL) begin
                     wl_d = wl_q + ONE_WL;
                  end else begin
                     wl_d = wl_q;
                  end
               end else begin
                  // Beyond memory capacity: consume the word silently.
                  data_d = data_q;
                  rdy_d  = 1'b0;
               end
               if ((idx_q + 32'd1) == n_q) begin
                  state_d = DRAIN;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         DRAIN: begin
            // The final strobe (if any) shares this cycle; close the window next.
            en_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: begin
            state_d = HEADER;
         end
      endcase
   end

   // Sequencer and output registers.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= HEADER;
         n_q     <= 32'd0;
         idx_q   <= 32'd0;
         data_q  <= 32'd0;
         en_q    <= 1'b0;
         rdy_q   <= 1'b0;
         done_q  <= 1'b0;
         wl_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         en_q    <= en_d;
         rdy_q   <= rdy_d;
         done_q  <= done_d;
         wl_q    <= wl_d;
      end
   end

   assign loader_data   = data_q;
   assign loader_enable = en_q;
   assign loader_ready  = rdy_q;
   assign done          = done_q;
   assign words_loaded  = wl_q;

   inst_loader_checker u_checker (
      .CLK           (CLK),
      .reset         (reset),
      .loader_enable (en_q),
      .loader_ready  (rdy_q)
   );

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed corner sequences, a vector table
// and randomized streams compared against a simple load model.
module tb_inst_loader;
   import loader_pkg::*;

   localparam int W   = 2;
   localparam int CAP = 4;

   logic          CLK = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [31:0]   loader_data;
   logic          loader_enable;
   logic          loader_ready;
   logic          done;
   logic [W:0]    words_loaded;

   inst_loader #(.INST_MEM_WIDTH(W)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .loader_data   (loader_data),
      .loader_enable (loader_enable),
      .loader_ready  (loader_ready),
      .done          (done),
      .words_loaded  (words_loaded)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- monitor / sink model ----------------
   int          cyc = 0;
   logic [31:0] got_q[$];
   int          last_rdy_cyc, en_rise_cyc, en_fall_cyc, en_rises, waddr;
   logic        done_at_fall;
   logic        en_h1 = 1'b0, en_h2 = 1'b0;
   logic [31:0] mem [0:CAP-1];

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (loader_enable && !en_h1) begin
         en_rise_cyc = cyc;
         en_rises++;
         waddr = 0;
      end
      if (!loader_enable && en_h1) begin
         en_fall_cyc  = cyc;
         done_at_fall = done;
      end
      if (loader_ready) begin
         got_q.push_back(loader_data);
         last_rdy_cyc = cyc;
         check("sink_guard", {29'd0, loader_enable, en_h1, en_h2}, 32'd7);
         if (waddr < CAP) mem[waddr] = loader_data;
         waddr++;
      end
      en_h2 = en_h1;
      en_h1 = loader_enable;
   end

   // ---------------- stimulus helpers ----------------
   int          last_byte_cyc;
   logic [31:0] stim_q[$];
   logic [31:0] exp_q[$];

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Drive one byte; returns 1 time unit after the edge that sampled it.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'd0;
      idle(2);
      reset = 1'b0;
      got_q.delete();
      en_rises     = 0;
      en_fall_cyc  = -1;
      en_rise_cyc  = -1;
      last_rdy_cyc = -1;
      done_at_fall = 1'b0;
      waddr        = 0;
   endtask

   // Header n followed by every word of stim_q; gap < 0 picks random gaps.
   task automatic run_stream(input logic [31:0] n, input int gap);
      logic [7:0] bytes_q[$];
      logic [31:0] w;
      for (int i = 0; i < 4; i++) bytes_q.push_back(n[31-8*i -: 8]);
      foreach (stim_q[k]) begin
         w = stim_q[k];
         for (int i = 0; i < 4; i++) bytes_q.push_back(w[31-8*i -: 8]);
      end
      foreach (bytes_q[k]) begin
         send_byte(bytes_q[k]);
         if (k == bytes_q.size() - 1) last_byte_cyc = cyc;
         else idle((gap < 0) ? int'($urandom_range(0, 2)) : gap);
      end
   endtask

   // Reference: the memory receives the first min(N, capacity) words in order.
   function automatic void model_load(input int n);
      exp_q.delete();
      for (int i = 0; i < n && i < CAP; i++) exp_q.push_back(stim_q[i]);
   endfunction

   task automatic verify(input string tag, input int n, input int exp_strobes, input int exp_wl);
      idle(3);
      model_load(n);
      check({tag, ".strobes"}, 32'(got_q.size()), 32'(exp_strobes));
      check({tag, ".model_n"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s.data%0d", tag, i), got_q[i], exp_q[i]);
      check({tag, ".wl"}, 32'(words_loaded), 32'(exp_wl));
      check({tag, ".done"}, 32'(done), 32'd1);
      check({tag, ".en_low"}, 32'(loader_enable), 32'd0);
      if (n > 0) begin
         check({tag, ".fall"}, 32'(en_fall_cyc), 32'(last_byte_cyc + 1));
         check({tag, ".done_at_fall"}, 32'(done_at_fall), 32'd1);
      end else begin
         check({tag, ".no_en"}, 32'(en_rises), 32'd0);
      end
   endtask

   typedef struct {
      int n;
      int gap;
      int exp_strobes;
      int exp_wl;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] hold;
   int          rises, nstrb, rn;

   initial begin
      tbl[0] = '{2, 3, 2, 2};
      tbl[1] = '{1, 0, 1, 1};
      tbl[2] = '{6, 0, 4, 4};
      tbl[3] = '{0, 1, 0, 0};
      tbl[4] = '{4, 1, 4, 4};
      tbl[5] = '{5, 2, 4, 4};

      // ---- basic load with 3-cycle gaps ----
      do_reset();
      check("rst.data", loader_data, 32'd0);
      check("rst.en", 32'(loader_enable), 32'd0);
      check("rst.rdy", 32'(loader_ready), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.wl", 32'(words_loaded), 32'd0);
      send_byte(8'h00); idle(3); send_byte(8'h00); idle(3);
      send_byte(8'h00); idle(3); send_byte(8'h02);
      check("basic.en_rise", 32'(loader_enable), 32'd1);
      idle(3);
      send_byte(8'h12); idle(3); send_byte(8'h34); idle(3);
      send_byte(8'h56); idle(3); send_byte(8'h78);
      check("basic.rdy1", 32'(loader_ready), 32'd1);
      check("basic.data1", loader_data, 32'h12345678);
      idle(1);
      check("basic.rdy1_pulse", 32'(loader_ready), 32'd0);
      idle(2);
      send_byte(8'h9A); idle(3); send_byte(8'hBC); idle(3);
      send_byte(8'hDE); idle(3); send_byte(8'hF0);
      check("basic.rdy2", 32'(loader_ready), 32'd1);
      check("basic.data2", loader_data, 32'h9ABCDEF0);
      check("basic.en_drain", 32'(loader_enable), 32'd1);
      idle(1);
      check("basic.en_fall", 32'(loader_enable), 32'd0);
      check("basic.done", 32'(done), 32'd1);
      check("basic.wl", 32'(words_loaded), 32'd2);
      check("basic.count", 32'(got_q.size()), 32'd2);

      // ---- post-done bytes are ignored ----
      hold  = loader_data;
      rises = en_rises;
      nstrb = got_q.size();
      for (int i = 0; i < 8; i++) send_byte(8'(i * 37 + 5));
      idle(3);
      check("post.strobes", 32'(got_q.size()), 32'(nstrb));
      check("post.rises", 32'(en_rises), 32'(rises));
      check("post.en", 32'(loader_enable), 32'd0);
      check("post.data", loader_data, hold);
      check("post.done", 32'(done), 32'd1);

      // ---- back-to-back bytes, NOP into mem[0] ----
      do_reset();
      stim_q = '{INST_NOP};
      run_stream(32'd1, 0);
      idle(3);
      check("b2b.count", 32'(got_q.size()), 32'd1);
      check("b2b.lead", 32'(last_rdy_cyc - en_rise_cyc >= 2), 32'd1);
      check("b2b.mem0", mem[0], INST_NOP);
      check("b2b.run_state", {30'd0, loader_enable, done}, 32'd1);

      // ---- empty load ----
      do_reset();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("empty.done_early", 32'(done), 32'd0);
      send_byte(8'h00);
      check("empty.done", 32'(done), 32'd1);
      check("empty.en", 32'(loader_enable), 32'd0);
      for (int i = 0; i < 8; i++) send_byte(8'hA5);
      idle(3);
      check("empty.rises", 32'(en_rises), 32'd0);
      check("empty.strobes", 32'(got_q.size()), 32'd0);
      check("empty.wl", 32'(words_loaded), 32'd0);

      // ---- reset in the middle of a load ----
      do_reset();
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      send_byte(8'h55); send_byte(8'h66);
      reset = 1'b1;
      idle(1);
      check("midrst.en", 32'(loader_enable), 32'd0);
      check("midrst.rdy", 32'(loader_ready), 32'd0);
      check("midrst.wl", 32'(words_loaded), 32'd0);
      reset = 1'b0;
      got_q.delete();
      stim_q = '{32'hAABBCCDD};
      run_stream(32'd1, 0);
      verify("midrst.fresh", 1, 1, 1);

      // ---- vector table ----
      foreach (tbl[t]) begin
         do_reset();
         stim_q.delete();
         for (int i = 0; i < tbl[t].n; i++) stim_q.push_back($urandom);
         run_stream(32'(tbl[t].n), tbl[t].gap);
         verify($sformatf("tbl%0d", t), tbl[t].n, tbl[t].exp_strobes, tbl[t].exp_wl);
      end

      // ---- randomized streams against the model ----
      for (int r = 0; r < 15; r++) begin
         do_reset();
         rn = $urandom_range(0, 9);
         stim_q.delete();
         for (int i = 0; i < rn; i++) stim_q.push_back($urandom);
         run_stream(32'(rn), -1);
         verify($sformatf("rnd%0d", r), rn, (rn < CAP) ? rn : CAP, (rn < CAP) ? rn : CAP);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_loader.md
# inst_loader

Word assembler and load sequencer that drives the write side of the instruction-memory load interface. It consumes a byte stream from the UART receiver: a 4-byte big-endian word count N, then N big-endian 32-bit instruction words. It frames the load window with `loader_enable` and emits one `loader_ready` strobe per assembled word. It sits between the UART receiver and the instruction memory. On completion it signals `done` so the core can be released.

## Interface
- `INST_MEM_WIDTH`, default 2: address width of the target instruction memory. Capacity is 2**INST_MEM_WIDTH words.
- `CLK`  in  1  system clock. All logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte, valid only when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte. Strobes may arrive on consecutive cycles.
- `loader_data`  out  32  assembled instruction word. Held stable between strobes.
- `loader_enable`  out  1  load window. High from header completion until drain end.
- `loader_ready`  out  1  one-cycle strobe: `loader_data` is a new word to be written.
- `done`  out  1  level. Load finished, held until reset.
- `words_loaded`  out  INST_MEM_WIDTH+1  count of words strobed to memory, saturating at capacity.

## Operation
- **Reset values:** all outputs 0 (`loader_data`, `loader_enable`, `loader_ready`, `done`, `words_loaded`). Byte counter is 0. State is HEADER.
- **Byte assembly:**
  - Each byte is shifted into a 32-bit register, first byte landing in bits 31:24.
  - A 2-bit byte counter wraps from 3 to 0; the wrap marks a complete word.
- **States:**
  - **HEADER:** collect 4 bytes into N.
    - On the 4th byte with N == 0, go to DONE; `loader_enable` is never raised.
    - On the 4th byte with N != 0, raise `loader_enable`, clear the word index, and go to LOAD.
  - **LOAD:** each completed word increments the word index.
    - If the index is below capacity, copy the word to `loader_data`, pulse `loader_ready`, and increment `words_loaded`.
    - If the index is at or above capacity, discard the word with no strobe. The bytes are still consumed so the stream stays aligned.
    - When the index reaches N, go to DRAIN.
  - **DRAIN:** one cycle with `loader_enable` still high. Then deassert `loader_enable` and go to DONE.
  - **DONE:** set `done`. All `rx_valid` is ignored; terminal until reset.
- **Counter widths:** N and the word index are 32-bit unsigned. Comparisons are unsigned and exact, with no wrap. `words_loaded` never exceeds 2**INST_MEM_WIDTH.
- **Reset mid-operation:** on the reset edge, `loader_enable` and `loader_ready` drop immediately. Partial bytes and the partial word are discarded and the state returns to HEADER.
- **Sink guard:** `loader_ready` must never be high unless `loader_enable` has been high for at least the two preceding cycles. The sink needs one cycle to enter its load state.
  - This holds structurally: the first data word needs at least 4 more bytes after header completion.
  - It is checked by assertion.
- **Extra bytes:** `rx_valid` in DRAIN or DONE has no effect.

## Timing
- All outputs are registered.
- `loader_ready` and the new `loader_data` appear in the cycle after the edge sampling the word's 4th byte.
- `loader_ready` is high for exactly one cycle.
- `loader_enable` rises in the cycle after the edge sampling the 4th header byte.
- After the last (N-th) word's 4th byte, the final `loader_ready` cycle is also the DRAIN cycle; `loader_enable` falls at the following edge.
  - Consequence: the sink sees `loader_ready` && `loader_enable` together, then `!loader_enable` on the next cycle.
  - This holds whether the last word was strobed or discarded.
- `done` rises in the same cycle that `loader_enable` falls. For N == 0 it rises one cycle after the 4th header byte.
- Minimum `loader_ready` spacing is 4 cycles, with back-to-back bytes.

## Structure
- A shared package `loader_pkg` holds:
  - the state enum `loader_state_t` (HEADER, LOAD, DRAIN, DONE);
  - `LOADER_HDR_BYTES` = 4;
  - `INST_NOP` = 32'h08000000, the memory fill value, used by benches.
- One natural sub-module, `byte_word_packer`: byte shift register, byte counter and word-complete strobe. The sequencer FSM, word index and output registers remain in `inst_loader`.

## Test plan
- **Basic load:** reset, then bytes 00 00 00 02 | 12 34 56 78 | 9A BC DE F0 with gaps of 3 cycles.
  - Two `loader_ready` strobes, with `loader_data` = 32'h12345678 then 32'h9ABCDEF0.
  - `loader_enable` falls 1 cycle after the second strobe; `done` = 1; `words_loaded` = 2.
- **Back-to-back bytes:** N=1, word 08000000, `rx_valid` high every cycle.
  - `loader_enable` leads `loader_ready` by at least 2 cycles; a single strobe.
  - Connected to the instruction memory, mem[0] reads 32'h08000000 and the memory returns to its run state.
- **Overflow:** `INST_MEM_WIDTH`=2, N=6, six distinct words.
  - Exactly 4 strobes (words 0-3); `words_loaded` = 4.
  - `loader_enable` stays high through the 6th word's bytes and then drains; `done` = 1.
- **Empty load:** N=0.
  - `loader_enable` never asserts; `done` rises 1 cycle after the 4th byte; trailing bytes are ignored.
- **Mid-load reset:** N=3; reset asserted after 6 data bytes.
  - Next cycle `loader_enable` = 0 and `loader_ready` = 0.
  - A fresh stream 00 00 00 01 | AA BB CC DD loads 32'hAABBCCDD as the first strobed word.
- **Post-done bytes:** after a completed load, send 8 further bytes.
  - No `loader_ready` or `loader_enable` activity; `loader_data` is unchanged.
